// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus (CDB) arbiter.
// Contents:
//   - CDB word field positions
//   - the no-write destination code
//   - the buffered result entry type
//   - a helper that builds a broadcast word
package cdb_pkg;

    localparam int DATA_W     = 10;
    localparam int TAG_W      = 2;
    localparam int CDB_W      = 16;

    localparam int R0_BIT     = 15;
    localparam int R1_BIT     = 14;
    localparam int R2_BIT     = 13;
    localparam int RS_POS_MSB = 12;
    localparam int RS_POS_LSB = 11;
    localparam int ALU_ID_BIT = 10;
    localparam int DATA_MSB   = 9;

    localparam logic [1:0] DEST_NONE = 2'd3;

    typedef struct packed {
        logic [1:0]        dest;
        logic [TAG_W-1:0]  rs_pos;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    localparam int ENTRY_W = $bits(cdb_entry_t);

    // Builds a CDB word. The top bits are the register write enables,
    // one-hot in dest; DEST_NONE gives no write enable at all.
    function automatic logic [CDB_W-1:0] cdb_word(input cdb_entry_t e, input logic alu_id);
        logic [CDB_W-1:0] w;
        w = '0;
        w[R0_BIT]                  = (e.dest == 2'd0);
        w[R1_BIT]                  = (e.dest == 2'd1);
        w[R2_BIT]                  = (e.dest == 2'd2);
        w[RS_POS_MSB:RS_POS_LSB]   = e.rs_pos;
        w[ALU_ID_BIT]              = alu_id;
        w[DATA_MSB:0]              = e.data;
        return w;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-ALU result buffer.
// Ports:
//   clock, reset (async, active-low), flush (sync clear)
//   push/din  - write an entry; ignored while full
//   pop/dout  - dout is the head entry; pop removes it; ignored while empty
//   full, empty, count - occupancy, all from registered state
module cdb_result_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 14,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A full buffer refuses a push even when the head pops on the same edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects results from two ALUs into per-ALU buffers and broadcasts one per
// cycle on the registered 16-bit CDB, round-robin between the ALUs.
// Ports:
//   clock, reset (async, active-low), flush (sync clear of buffers and CDB)
//   aluN_valid/aluN_ready - result handshake, N = 0,1
//   aluN_dest/rs_pos/data - result payload
//   cdb, cdb_valid        - registered broadcast word and its qualifier
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int DATA_W     = cdb_pkg::DATA_W,
    parameter int TAG_W      = cdb_pkg::TAG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              alu0_valid,
    output logic              alu0_ready,
    input  logic [1:0]        alu0_dest,
    input  logic [TAG_W-1:0]  alu0_rs_pos,
    input  logic [DATA_W-1:0] alu0_data,
    input  logic              alu1_valid,
    output logic              alu1_ready,
    input  logic [1:0]        alu1_dest,
    input  logic [TAG_W-1:0]  alu1_rs_pos,
    input  logic [DATA_W-1:0] alu1_data,
    output logic [CDB_W-1:0]  cdb,
    output logic              cdb_valid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    cdb_entry_t       head [2];
    cdb_entry_t       din  [2];
    logic [1:0]       push, pop, full, empty;
    logic [CNT_W-1:0] count [2];

    logic             rr_q, rr_d;
    logic [CDB_W-1:0] cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;
    logic             grant_valid, grant_id;

    assign din[0] = '{dest: alu0_dest, rs_pos: alu0_rs_pos, data: alu0_data};
    assign din[1] = '{dest: alu1_dest, rs_pos: alu1_rs_pos, data: alu1_data};

    assign alu0_ready = (count[0] < CNT_W'(FIFO_DEPTH));
    assign alu1_ready = (count[1] < CNT_W'(FIFO_DEPTH));

    // flush wins over a simultaneous result: it is dropped, not buffered.
    assign push[0] = alu0_valid & ~full[0] & ~flush;
    assign push[1] = alu1_valid & ~full[1] & ~flush;

    for (genvar k = 0; k < 2; k++) begin : g_buf
        cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .push  (push[k]),
            .din   (din[k]),
            .pop   (pop[k]),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .count (count[k])
        );
    end

    // Round-robin only matters when both heads are present.
    assign grant_valid = ~empty[0] | ~empty[1];
    assign grant_id    = (~empty[0] & ~empty[1]) ? rr_q : empty[0];
    assign pop[0]      = grant_valid & ~grant_id & ~flush;
    assign pop[1]      = grant_valid &  grant_id & ~flush;

    always_comb begin
        cdb_d       = '0;
        cdb_valid_d = 1'b0;
        rr_d        = rr_q;
        if (flush) begin
            rr_d = 1'b0;
        end else if (grant_valid) begin
            cdb_d       = cdb_word(head[grant_id], grant_id);
            cdb_valid_d = 1'b1;
            rr_d        = ~grant_id;
        end
    end

    // The CDB word is rebuilt every cycle, so write enables last exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            rr_q        <= rr_d;
        end
    end

    assign cdb       = cdb_q;
    assign cdb_valid = cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        alu0_valid = 1'b0, alu1_valid = 1'b0;
    logic        alu0_ready, alu1_ready;
    logic [1:0]  alu0_dest = '0, alu1_dest = '0;
    logic [1:0]  alu0_rs_pos = '0, alu1_rs_pos = '0;
    logic [9:0]  alu0_data = '0, alu1_data = '0;
    logic [15:0] cdb;
    logic        cdb_valid;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alu0_valid(alu0_valid), .alu0_ready(alu0_ready), .alu0_dest(alu0_dest),
        .alu0_rs_pos(alu0_rs_pos), .alu0_data(alu0_data),
        .alu1_valid(alu1_valid), .alu1_ready(alu1_ready), .alu1_dest(alu1_dest),
        .alu1_rs_pos(alu1_rs_pos), .alu1_data(alu1_data),
        .cdb(cdb), .cdb_valid(cdb_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected broadcast word from the field layout, by plain arithmetic.
    function automatic logic [15:0] exp_word(input int alu, input int dest, input int rs, input int data);
        int w;
        w = (dest < 3) ? (32'h8000 >> dest) : 0;
        w = w + rs * 2048 + alu * 1024 + data;
        return w[15:0];
    endfunction

    // Inputs change right after a negedge; outputs are sampled at negedges.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input int alu, input logic v, input logic [1:0] d, input logic [1:0] r, input logic [9:0] x);
        if (alu == 0) begin
            alu0_valid = v; alu0_dest = d; alu0_rs_pos = r; alu0_data = x;
        end else begin
            alu1_valid = v; alu1_dest = d; alu1_rs_pos = r; alu1_data = x;
        end
    endtask

    task automatic idle();
        alu0_valid = 1'b0;
        alu1_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    typedef struct {
        int          alu;
        logic [1:0]  dest;
        logic [1:0]  rs;
        logic [9:0]  data;
        logic [15:0] exp;
    } vec_t;

    // Reference model state for the random phase.
    logic [13:0] mq0[$], mq1[$];
    int          m_rr;
    logic [15:0] m_cdb;
    logic        m_vld;

    initial begin
        vec_t vecs[6];
        logic [15:0] seen[$];
        logic [9:0]  acc0[$], acc1[$];
        int          bad;

        vecs[0] = '{0, 2'd1, 2'd2, 10'd7,    16'h5007};
        vecs[1] = '{1, 2'd3, 2'd3, 10'd5,    16'h1C05};
        vecs[2] = '{0, 2'd0, 2'd0, 10'd1,    16'h8001};
        vecs[3] = '{1, 2'd2, 2'd1, 10'h3FF,  16'h2FFF};
        vecs[4] = '{0, 2'd3, 2'd0, 10'd0,    16'h0000};
        vecs[5] = '{1, 2'd0, 2'd2, 10'h155,  16'h9555};

        // Reset state.
        #12;
        check("reset_cdb", 32'(cdb), 32'h0);
        check("reset_valid", 32'(cdb_valid), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_reset_ready", {30'h0, alu1_ready, alu0_ready}, 32'h3);

        // Single uncontended results from the table.
        for (int i = 0; i < 6; i++) begin
            do_flush();
            drive(vecs[i].alu, 1'b1, vecs[i].dest, vecs[i].rs, vecs[i].data);
            step();
            idle();
            check($sformatf("vec%0d_not_yet", i), 32'(cdb_valid), 32'h0);
            step();
            check($sformatf("vec%0d_cdb", i), 32'(cdb), 32'(vecs[i].exp));
            check($sformatf("vec%0d_valid", i), 32'(cdb_valid), 32'h1);
            step();
            check($sformatf("vec%0d_one_cycle", i), {15'h0, cdb_valid, cdb}, 32'h0);
        end

        // Both ALUs at the same edge, twice: ALU0 first each time.
        do_flush();
        for (int rep = 0; rep < 2; rep++) begin
            drive(0, 1'b1, 2'd0, 2'd0, 10'd1);
            drive(1, 1'b1, 2'd2, 2'd1, 10'h3FF);
            step();
            idle();
            step();
            check($sformatf("both%0d_first", rep), {15'h0, cdb_valid, cdb}, 32'h1_8001);
            step();
            check($sformatf("both%0d_second", rep), {15'h0, cdb_valid, cdb}, 32'h1_2FFF);
            step();
            check($sformatf("both%0d_idle", rep), 32'(cdb_valid), 32'h0);
        end

        // Streaming from both ALUs: alternation, order, no loss or duplication.
        do_flush();
        for (int c = 0; c < 24; c++) begin
            if (cdb_valid) seen.push_back(cdb);
            if (c < 6) begin
                drive(0, 1'b1, 2'd3, 2'd0, 10'(c));
                drive(1, 1'b1, 2'd3, 2'd0, 10'(10'h100 + c));
                if (alu0_ready) acc0.push_back(10'(c));
                if (alu1_ready) acc1.push_back(10'(10'h100 + c));
            end else begin
                idle();
            end
            step();
        end
        check("stream_count", seen.size(), acc0.size() + acc1.size());
        bad = 0;
        for (int i = 0; i < 4 && i < seen.size(); i++)
            if (int'(seen[i][10]) != (i % 2)) bad++;
        check("stream_alternate", bad, 0);
        bad = 0;
        foreach (seen[i]) begin
            if (seen[i][10] == 1'b0) begin
                if (acc0.size() == 0 || acc0.pop_front() != seen[i][9:0]) bad++;
            end else begin
                if (acc1.size() == 0 || acc1.pop_front() != seen[i][9:0]) bad++;
            end
        end
        check("stream_order", bad + acc0.size() + acc1.size(), 0);

        // Fill ALU0 while ALU1 holds priority, then flush with results offered.
        do_flush();
        drive(0, 1'b1, 2'd0, 2'd0, 10'd3);
        step();
        idle();
        step();                               // ALU0 granted alone -> priority to ALU1
        step();
        drive(0, 1'b1, 2'd0, 2'd0, 10'd4);
        drive(1, 1'b1, 2'd1, 2'd0, 10'd5);
        step();
        step();                               // ALU1 granted, ALU0 now holds two
        check("fill_ready0", 32'(alu0_ready), 32'h0);
        check("fill_ready1", 32'(alu1_ready), 32'h1);
        drive(0, 1'b1, 2'd0, 2'd0, 10'd6);
        drive(1, 1'b1, 2'd1, 2'd0, 10'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush_cdb", {15'h0, cdb_valid, cdb}, 32'h0);
        check("flush_ready", {30'h0, alu1_ready, alu0_ready}, 32'h3);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cdb_valid) bad++;
        end
        check("flush_nothing_left", bad, 0);

        // Async reset in the middle of a broadcast with both buffers holding entries.
        do_flush();
        drive(0, 1'b1, 2'd1, 2'd1, 10'd9);
        drive(1, 1'b1, 2'd2, 2'd2, 10'd8);
        step();
        step();
        idle();
        check("pre_reset_valid", 32'(cdb_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_cdb", {15'h0, cdb_valid, cdb}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        check("reset_release_ready", {30'h0, alu1_ready, alu0_ready}, 32'h3);
        step();
        check("reset_release_idle", 32'(cdb_valid), 32'h0);

        // Randomized traffic against a queue-based model.
        do_flush();
        mq0.delete(); mq1.delete();
        m_rr = 0; m_cdb = '0; m_vld = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic r0, r1, f, v0, v1;
            logic [13:0] e0, e1, h;
            int g;
            r0 = (mq0.size() < DEPTH);
            r1 = (mq1.size() < DEPTH);
            check("rnd_cdb", {15'h0, cdb_valid, cdb}, {15'h0, m_vld, m_cdb});
            check("rnd_ready", {30'h0, alu1_ready, alu0_ready}, {30'h0, r1, r0});
            f  = ($urandom_range(0, 19) == 0);
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            e0 = 14'($urandom);
            e1 = 14'($urandom);
            drive(0, v0, e0[13:12], e0[11:10], e0[9:0]);
            drive(1, v1, e1[13:12], e1[11:10], e1[9:0]);
            flush = f;
            if (f) begin
                mq0.delete(); mq1.delete();
                m_rr = 0; m_cdb = '0; m_vld = 1'b0;
            end else begin
                if (mq0.size() > 0 || mq1.size() > 0) begin
                    if (mq0.size() > 0 && mq1.size() > 0) g = m_rr;
                    else g = (mq1.size() > 0) ? 1 : 0;
                    h = (g == 0) ? mq0.pop_front() : mq1.pop_front();
                    m_cdb = exp_word(g, h[13:12], h[11:10], h[9:0]);
                    m_vld = 1'b1;
                    m_rr = 1 - g;
                end else begin
                    m_cdb = '0;
                    m_vld = 1'b0;
                end
                if (v0 && r0) mq0.push_back(e0);
                if (v1 && r1) mq1.push_back(e1);
            end
            step();
        end
        flush = 1'b0;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
